// File: rtl/ica_reg_sink.sv
// ICA/DCA register-write sink: buffers writes and applies them during blanking (apply_en).
// Define ICA_SINK_FIFO_EN for the blanking-gated FIFO; otherwise writes apply 1 clock later.
module ica_reg_sink #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [6:0]               register_adr,
  input  logic [23:0]              register_data,
  input  logic                     register_write,
  input  logic                     apply_en,
  output logic                     clut_we,
  output logic [7:0]               clut_adr,
  output logic [23:0]              clut_data,
  output logic [23:0]              image_coding_method,
  output logic [23:0]              transparency_control,
  output logic [23:0]              plane_order,
  output logic [23:0]              backdrop_color,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic        w_dec_valid;
  logic [6:0]  w_dec_adr;
  logic [23:0] w_dec_data;

`ifdef ICA_SINK_FIFO_EN
  logic [30:0] r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        r_overflow;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_pop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = apply_en && !w_empty;
  // A same-cycle pop frees the slot, so a push at full is still accepted.
  assign w_push  = register_write && (!w_full || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wptr[AW-1:0]] <= {register_adr, register_data};
        r_wptr                <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (register_write && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign w_dec_valid              = w_pop;
  assign {w_dec_adr, w_dec_data}  = r_mem[r_rptr[AW-1:0]];
  assign fifo_level               = r_wptr - r_rptr;
  assign overflow                 = r_overflow;
`else
  logic w_unused_apply_en;

  assign w_unused_apply_en = apply_en;
  assign w_dec_valid       = register_write;
  assign w_dec_adr         = register_adr;
  assign w_dec_data        = register_data;
  assign fifo_level        = '0;
  assign overflow          = 1'b0;
`endif

  logic        r_clut_we;
  logic [7:0]  r_clut_adr;
  logic [23:0] r_clut_data;
  logic [23:0] r_icm;
  logic [23:0] r_tc;
  logic [23:0] r_po;
  logic [23:0] r_bd;
  logic [1:0]  r_bank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_clut_we   <= 1'b0;
      r_clut_adr  <= '0;
      r_clut_data <= '0;
      r_icm       <= '0;
      r_tc        <= '0;
      r_po        <= '0;
      r_bd        <= '0;
      r_bank      <= '0;
    end else begin
      r_clut_we <= 1'b0;
      if (w_dec_valid) begin
        if (!w_dec_adr[6]) begin
          r_clut_we   <= 1'b1;
          r_clut_adr  <= {r_bank, w_dec_adr[5:0]};
          r_clut_data <= w_dec_data;
        end else begin
          case (w_dec_adr)
            7'h40:   r_icm  <= w_dec_data;
            7'h41:   r_tc   <= w_dec_data;
            7'h42:   r_po   <= w_dec_data;
            7'h43:   r_bank <= w_dec_data[1:0];
            7'h58:   r_bd   <= w_dec_data;
            default: ;
          endcase
        end
      end
    end
  end

  assign clut_we              = r_clut_we;
  assign clut_adr             = r_clut_adr;
  assign clut_data            = r_clut_data;
  assign image_coding_method  = r_icm;
  assign transparency_control = r_tc;
  assign plane_order          = r_po;
  assign backdrop_color       = r_bd;

endmodule

// File: tb/tb_ica_reg_sink.sv
// Bench for ica_reg_sink: directed scenarios plus random traffic against a queue-based model.
module tb_ica_reg_sink;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  register_adr;
  logic [23:0] register_data;
  logic        register_write;
  logic        apply_en;
  logic        clut_we;
  logic [7:0]  clut_adr;
  logic [23:0] clut_data;
  logic [23:0] image_coding_method;
  logic [23:0] transparency_control;
  logic [23:0] plane_order;
  logic [23:0] backdrop_color;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        overflow;

  always #5 clk = ~clk;

  ica_reg_sink #(.DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .reset                (reset),
    .register_adr         (register_adr),
    .register_data        (register_data),
    .register_write       (register_write),
    .apply_en             (apply_en),
    .clut_we              (clut_we),
    .clut_adr             (clut_adr),
    .clut_data            (clut_data),
    .image_coding_method  (image_coding_method),
    .transparency_control (transparency_control),
    .plane_order          (plane_order),
    .backdrop_color       (backdrop_color),
    .fifo_level           (fifo_level),
    .overflow             (overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending writes as a queue, outputs as plain variables.
  logic [30:0] m_q[$];
  logic [23:0] m_icm, m_tc, m_po, m_bd, m_clut_data;
  logic [7:0]  m_clut_adr;
  logic        m_clut_we, m_ovf;
  logic [1:0]  m_bank;

  function void m_reset();
    m_q.delete();
    m_icm = '0; m_tc = '0; m_po = '0; m_bd = '0;
    m_clut_data = '0; m_clut_adr = '0; m_clut_we = 1'b0; m_ovf = 1'b0; m_bank = '0;
  endfunction

  function void m_apply(logic [6:0] a, logic [23:0] d);
    if (a < 7'h40) begin
      m_clut_we   = 1'b1;
      m_clut_adr  = {m_bank, a[5:0]};
      m_clut_data = d;
    end else if (a == 7'h40) m_icm = d;
    else if (a == 7'h41) m_tc = d;
    else if (a == 7'h42) m_po = d;
    else if (a == 7'h43) m_bank = d[1:0];
    else if (a == 7'h58) m_bd = d;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int exp_level;
`ifdef ICA_SINK_FIFO_EN
    exp_level = m_q.size();
`else
    exp_level = 0;
`endif
    chk("clut_we", {31'b0, clut_we}, {31'b0, m_clut_we});
    chk("clut_adr", {24'b0, clut_adr}, {24'b0, m_clut_adr});
    chk("clut_data", {8'b0, clut_data}, {8'b0, m_clut_data});
    chk("image_coding_method", {8'b0, image_coding_method}, {8'b0, m_icm});
    chk("transparency_control", {8'b0, transparency_control}, {8'b0, m_tc});
    chk("plane_order", {8'b0, plane_order}, {8'b0, m_po});
    chk("backdrop_color", {8'b0, backdrop_color}, {8'b0, m_bd});
    chk("fifo_level", 32'(fifo_level), 32'(exp_level));
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_clut_we"}, {31'b0, clut_we}, 32'd0);
    chk({tag, "_clut_adr"}, {24'b0, clut_adr}, 32'd0);
    chk({tag, "_clut_data"}, {8'b0, clut_data}, 32'd0);
    chk({tag, "_icm"}, {8'b0, image_coding_method}, 32'd0);
    chk({tag, "_tc"}, {8'b0, transparency_control}, 32'd0);
    chk({tag, "_po"}, {8'b0, plane_order}, 32'd0);
    chk({tag, "_bd"}, {8'b0, backdrop_color}, 32'd0);
    chk({tag, "_level"}, 32'(fifo_level), 32'd0);
    chk({tag, "_overflow"}, {31'b0, overflow}, 32'd0);
  endtask

  // Drive one cycle of inputs, advance the model at the edge, then compare.
  task automatic step(logic w, logic [6:0] a, logic [23:0] d, logic en);
    logic [30:0] e;
    logic        pop;
    register_write = w;
    register_adr   = a;
    register_data  = d;
    apply_en       = en;
    @(posedge clk);
    m_clut_we = 1'b0;
`ifdef ICA_SINK_FIFO_EN
    pop = en && (m_q.size() > 0);
    if (w) begin
      if (m_q.size() < DEPTH || pop) m_q.push_back({a, d});
      else m_ovf = 1'b1;
    end
    if (pop) begin
      e = m_q.pop_front();
      m_apply(e[30:24], e[23:0]);
    end
`else
    pop = 1'b0;
    e   = '0;
    if (w) m_apply(a, d);
`endif
    #1;
    check_all();
  endtask

  task automatic idle(int n, logic en);
    for (int i = 0; i < n; i++) step(1'b0, 7'h7F, 24'h0, en);
  endtask

  initial begin
    reset          = 1'b1;
    register_write = 1'b0;
    register_adr   = '0;
    register_data  = '0;
    apply_en       = 1'b0;
    m_reset();
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Latency: 0x40 write lands within 2 clocks, FIFO back to empty.
    step(1'b1, 7'h40, 24'h000F0F, 1'b1);
    step(1'b0, 7'h00, 24'h0, 1'b1);
    chk("lat_icm", {8'b0, image_coding_method}, 32'h000F0F);
    chk("lat_level", 32'(fifo_level), 32'd0);

    // Bank select then CLUT write.
    step(1'b1, 7'h43, 24'h000002, 1'b0);
    step(1'b1, 7'h05, 24'h112233, 1'b0);
`ifdef ICA_SINK_FIFO_EN
    chk("bank_level", 32'(fifo_level), 32'd2);
    chk("bank_hold_we", {31'b0, clut_we}, 32'd0);
    idle(2, 1'b1);
`endif
    chk("bank_we", {31'b0, clut_we}, 32'd1);
    chk("bank_adr", {24'b0, clut_adr}, 32'h85);
    chk("bank_data", {8'b0, clut_data}, 32'h112233);
    idle(1, 1'b1);
    chk("bank_we_drop", {31'b0, clut_we}, 32'd0);

    // Overflow: 9 writes while closed, then drain.
    for (int i = 0; i < 9; i++) step(1'b1, 7'(i), {8'(i + 1), 16'hA55A}, 1'b0);
`ifdef ICA_SINK_FIFO_EN
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_flag", {31'b0, overflow}, 32'd1);
`endif
    idle(10, 1'b1);

    // Async reset between edges with 4 entries pending.
    for (int i = 0; i < 4; i++) step(1'b1, 7'h41 + 7'(i % 2), 24'h00C0DE + 24'(i), 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_zero("async_rst");
    m_reset();
    @(posedge clk);
    #2;
    reset = 1'b0;
    idle(4, 1'b1);
    check_zero("post_rst");

    // Push at full in the same cycle as a pop.
    for (int i = 0; i < 8; i++) step(1'b1, 7'h10 + 7'(i), 24'h300000 + 24'(i), 1'b0);
    step(1'b1, 7'h41, 24'hABCDEF, 1'b1);
`ifdef ICA_SINK_FIFO_EN
    chk("full_push_level", 32'(fifo_level), 32'd8);
`endif
    chk("full_push_ovf", {31'b0, overflow}, 32'd0);
    idle(9, 1'b1);
    chk("full_push_tc", {8'b0, transparency_control}, 32'hABCDEF);

    // Window close after 3 of 5 pops.
    for (int i = 0; i < 5; i++) step(1'b1, 7'h20 + 7'(i), 24'h400000 + 24'(i), 1'b0);
    idle(3, 1'b1);
    idle(2, 1'b0);
`ifdef ICA_SINK_FIFO_EN
    chk("win_level", 32'(fifo_level), 32'd2);
`endif
    idle(2, 1'b1);
    chk("win_level_end", 32'(fifo_level), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] a;
      case ($urandom_range(0, 5))
        0, 1:    a = 7'($urandom_range(0, 63));
        2:       a = 7'h40 + 7'($urandom_range(0, 3));
        3:       a = 7'h58;
        default: a = 7'($urandom);
      endcase
      step(($urandom_range(0, 9) < 6), a, 24'($urandom), $urandom_range(0, 1) == 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
